// File: rtl/alu_op_issuer.sv
// ---------------------------------------------------------------------------
// alu_op_issuer
//
// Purpose:
//   Sits between a host command source and the ALU control/datapath pair.
//   Commands (OP, A, B) are buffered in a small FIFO and issued one at a time
//   as registered ALU_OP/A/B. The block then waits ALU_LAT cycles, samples
//   the ALU's combinational result and presents it on a valid/ready result
//   port. OP 111 is illegal: it never reaches the ALU and instead returns an
//   error-flagged zero result.
//
// Parameters:
//   WIDTH    operand/result width in bits
//   DEPTH    command FIFO entries (power of 2, >= 2)
//   ALU_LAT  cycles ALU_OP/A/B are held before ALU_Y is sampled (>= 1)
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_cmd_valid   command present
//   o_cmd_ready   FIFO can accept (count < DEPTH)
//   i_cmd_op      3-bit OP code (111 = illegal)
//   i_cmd_a/b     operands
//   o_alu_op/a/b  registered OP and operands driven to the ALU
//   i_alu_y       ALU result, combinational from o_alu_op/a/b
//   o_res_valid   result held
//   i_res_ready   consumer accepts result
//   o_res_y       captured result
//   o_res_err     result belongs to an illegal OP
//   o_busy        command in flight or FIFO non-empty
//   o_fifo_cnt    entries currently buffered
// ---------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [2:0]               i_cmd_op,
    input  logic [WIDTH-1:0]         i_cmd_a,
    input  logic [WIDTH-1:0]         i_cmd_b,
    output logic [2:0]               o_alu_op,
    output logic [WIDTH-1:0]         o_alu_a,
    output logic [WIDTH-1:0]         o_alu_b,
    input  logic [WIDTH-1:0]         i_alu_y,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [WIDTH-1:0]         o_res_y,
    output logic                     o_res_err,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_fifo_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam int CMD_W = 3 + 2 * WIDTH;

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(ALU_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);
    localparam logic [2:0]       OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Command FIFO
    // -----------------------------------------------------------------------
    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_fifo_empty;
    logic [CMD_W-1:0] w_cmd_word;
    logic [CMD_W-1:0] w_head_word;
    logic [2:0]       w_head_op;
    logic [WIDTH-1:0] w_head_a;
    logic [WIDTH-1:0] w_head_b;

    // Ready is a function of the count alone: a pop in the same cycle does
    // not open a slot for a push while full.
    assign o_cmd_ready  = (r_cnt < CNT_FULL);
    assign w_push       = i_cmd_valid && o_cmd_ready;
    assign w_fifo_empty = (r_cnt == '0);
    assign w_cmd_word   = {i_cmd_op, i_cmd_a, i_cmd_b};

    // The head is read combinationally so that a command accepted in one
    // cycle can be popped in the next and reach the ALU registers one cycle
    // after that. The FIFO is only a handful of entries deep.
    assign w_head_word = r_mem[r_rd_ptr];
    assign w_head_op   = w_head_word[CMD_W-1 -: 3];
    assign w_head_a    = w_head_word[2*WIDTH-1 -: WIDTH];
    assign w_head_b    = w_head_word[WIDTH-1:0];

    // Storage has no reset; validity is tracked by the count and pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_word;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Issue FSM
    // -----------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;
    logic [LAT_W-1:0] r_lat;
    logic             w_lat_zero;
    logic             w_issue;
    logic             w_illegal;
    logic             w_capture;
    logic             w_res_done;

    assign w_lat_zero = (r_lat == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_illegal    = 1'b0;
        w_capture    = 1'b0;
        w_res_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_head_op == OP_ILLEGAL) begin
                        // Illegal commands bypass the ALU entirely.
                        w_illegal    = 1'b1;
                        w_state_next = S_RESP;
                    end else begin
                        w_issue      = 1'b1;
                        w_state_next = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (w_lat_zero) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                // Returning to IDLE costs one bubble cycle before the next
                // pop; issue is never back-to-back.
                if (i_res_ready) begin
                    w_res_done   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // ALU operand registers, latency counter and result holding registers
    // -----------------------------------------------------------------------
    logic [2:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_y;
    logic             r_res_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu_op    <= 3'b000;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_lat       <= '0;
            r_res_valid <= 1'b0;
            r_res_y     <= '0;
            r_res_err   <= 1'b0;
        end else begin
            // ALU registers keep the last issued command after completion.
            if (w_issue) begin
                r_alu_op <= w_head_op;
                r_alu_a  <= w_head_a;
                r_alu_b  <= w_head_b;
                r_lat    <= LAT_INIT;
            end else if ((r_state == S_EXEC) && !w_lat_zero) begin
                r_lat <= r_lat - LAT_ONE;
            end

            if (w_capture) begin
                r_res_y     <= i_alu_y;
                r_res_err   <= 1'b0;
                r_res_valid <= 1'b1;
            end else if (w_illegal) begin
                r_res_y     <= '0;
                r_res_err   <= 1'b1;
                r_res_valid <= 1'b1;
            end else if (w_res_done) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign o_alu_op    = r_alu_op;
    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_res_valid = r_res_valid;
    assign o_res_y     = r_res_y;
    assign o_res_err   = r_res_err;
    assign o_busy      = (r_state != S_IDLE) || !w_fifo_empty;
    assign o_fifo_cnt  = r_cnt;

endmodule
